// File: rtl/kernel_pkg.sv
// Shared constants and types for the kernel register-file write path.
//   KERNEL_WIDTH   : kernel word width (matches register-file data width)
//   KERNEL_ENTRIES : words per kernel
//   KERNEL_ADDR_W  : register-file address width
//   loader_state_t : state encoding of the kernel loader FSM
package kernel_pkg;

  localparam int KERNEL_WIDTH   = 16;
  localparam int KERNEL_ENTRIES = 18;
  localparam int KERNEL_ADDR_W  = 5;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_FLUSH = 2'd2,
    LD_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/kernel_reg_loader.sv
// kernel_reg_loader
// Write-side sequencer for the kernel register file. Accepts kernel words on a
// valid/ready stream and writes them to entries 0..NUM_ENTRIES-1 in order, then
// pulses done and raises kernel_valid once the whole kernel is resident.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   pulse: begin loading a new kernel (honoured only in IDLE)
//   in_data      in   kernel word from the fetch path
//   in_valid     in   in_data valid
//   in_ready     out  loader accepts in_data this cycle (LOAD state only)
//   write_addr   out  register-file write address (registered)
//   write_en     out  register-file write enable (registered)
//   din          out  register-file write data (registered)
//   busy         out  LOAD or FLUSH in progress
//   done         out  one-cycle pulse after the last word has been written
//   kernel_valid out  register file holds a complete kernel
module kernel_reg_loader
  import kernel_pkg::*;
#(
  parameter int WIDTH       = KERNEL_WIDTH,
  parameter int NUM_ENTRIES = KERNEL_ENTRIES,
  parameter int ADDR_W      = KERNEL_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_en,
  output logic [WIDTH-1:0]  din,
  output logic              busy,
  output logic              done,
  output logic              kernel_valid
);

  // One extra bit so the counter can represent NUM_ENTRIES itself after the
  // final handshake without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ENTRIES - 1);

  loader_state_t     state_reg, state_next;
  logic [CNT_W-1:0]  counter_reg, counter_next;
  logic              write_en_reg, write_en_next;
  logic [ADDR_W-1:0] write_addr_reg, write_addr_next;
  logic [WIDTH-1:0]  din_reg, din_next;
  logic              kernel_valid_reg, kernel_valid_next;
  logic              handshake;

  assign handshake = in_valid && (state_reg == LD_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= LD_IDLE;
      counter_reg      <= '0;
      write_en_reg     <= 1'b0;
      write_addr_reg   <= '0;
      din_reg          <= '0;
      kernel_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      counter_reg      <= counter_next;
      write_en_reg     <= write_en_next;
      write_addr_reg   <= write_addr_next;
      din_reg          <= din_next;
      kernel_valid_reg <= kernel_valid_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    counter_next      = counter_reg;
    write_en_next     = 1'b0;
    write_addr_next   = write_addr_reg;
    din_next          = din_reg;
    kernel_valid_next = kernel_valid_reg;

    case (state_reg)
      LD_IDLE: begin
        if (start) begin
          state_next        = LD_LOAD;
          counter_next      = '0;
          // A new load invalidates the resident kernel immediately.
          kernel_valid_next = 1'b0;
        end
      end

      LD_LOAD: begin
        if (handshake) begin
          write_en_next   = 1'b1;
          // counter_reg <= NUM_ENTRIES-1 here, so the low bits are the address.
          write_addr_next = counter_reg[ADDR_W-1:0];
          din_next        = in_data;
          counter_next    = counter_reg + 1'b1;
          if (counter_reg == LAST_IDX) begin
            state_next = LD_FLUSH;
          end
        end
      end

      // The last word's registered write is on the outputs this cycle.
      LD_FLUSH: begin
        state_next = LD_DONE;
      end

      LD_DONE: begin
        kernel_valid_next = 1'b1;
        state_next        = LD_IDLE;
      end

      default: begin
        state_next = LD_IDLE;
      end
    endcase
  end

  assign in_ready     = (state_reg == LD_LOAD);
  assign busy         = (state_reg == LD_LOAD) || (state_reg == LD_FLUSH);
  assign done         = (state_reg == LD_DONE);
  assign write_en     = write_en_reg;
  assign write_addr   = write_addr_reg;
  assign din          = din_reg;
  assign kernel_valid = kernel_valid_reg;

endmodule

// File: tb/tb_kernel_reg_loader.sv
// Testbench for kernel_reg_loader: drives the word stream, models the register
// file written by the loader, and checks handshake timing, write sequencing,
// done/kernel_valid behaviour, reset abandonment and the address bound.
module tb_kernel_reg_loader;
  import kernel_pkg::*;

  localparam int N  = 18;
  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] write_addr;
  logic          write_en;
  logic [W-1:0]  din;
  logic          busy;
  logic          done;
  logic          kernel_valid;

  kernel_reg_loader #(
    .WIDTH       (W),
    .NUM_ENTRIES (N),
    .ADDR_W      (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .write_addr   (write_addr),
    .write_en     (write_en),
    .din          (din),
    .busy         (busy),
    .done         (done),
    .kernel_valid (kernel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the loader's write port.
  logic [W-1:0] regfile [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (write_en) regfile[write_addr] <= din;
  end

  int checks;
  int errors;
  int exp_addr;
  int done_count;
  int exp_done;
  int addr_viol;
  logic [W-1:0] cur_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Post-edge observation of the write port: every write must be the next
  // address in sequence carrying the word for that address.
  task automatic observe();
    if (write_en) begin
      if (int'(write_addr) >= N) addr_viol++;
      chk("wr_addr", 32'(write_addr), 32'(exp_addr));
      chk("wr_din", 32'(din), 32'(cur_base + W'(exp_addr)));
      exp_addr++;
    end
    if (done) done_count++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_write_en"}, 32'(write_en), 32'd0);
    chk({tag, "_write_addr"}, 32'(write_addr), 32'd0);
    chk({tag, "_din"}, 32'(din), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_kernel_valid"}, 32'(kernel_valid), 32'd0);
  endtask

  task automatic chk_regs(input string tag, input logic [W-1:0] base);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_reg"}, 32'(regfile[k]), 32'(base + W'(k)));
    end
  endtask

  // mode 0: in_valid held high; mode 1: 1,0,0,1 pattern; mode 2: random gaps.
  // start_mid >= 0 pulses start alongside that word; start_flush pulses start in FLUSH.
  task automatic load_kernel(input logic [W-1:0] base, input int mode,
                             input int start_mid, input bit start_flush);
    int  k;
    int  cyc;
    bit  v;
    bit  hs;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    cur_base = base;
    exp_addr = 0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chk("start_kv_drop", 32'(kernel_valid), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? (base + W'(k)) : 16'hDEAD;
      start    = (k == start_mid) && v;
      hs       = v && in_ready;
      step();
      if (hs) k++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (k < N) chk("load_timeout", 32'(k), 32'(N));
    // FLUSH: last write visible, no longer accepting.
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_write_en", 32'(write_en), 32'd1);
    chk("flush_addr", 32'(write_addr), 32'(N - 1));
    chk("flush_done", 32'(done), 32'd0);
    start = start_flush;
    step();
    start = 1'b0;
    exp_done++;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_write_en", 32'(write_en), 32'd0);
    step();
    chk("post_done", 32'(done), 32'd0);
    chk("post_kv", 32'(kernel_valid), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("done_count", 32'(done_count), 32'(exp_done));
  endtask

  typedef struct {
    logic          start;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          exp_ready;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_din;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_kv;
  } vec_t;

  vec_t vecs [0:N+2];
  logic [W-1:0] rbase;

  initial begin
    checks     = 0;
    errors     = 0;
    exp_addr   = 0;
    done_count = 0;
    exp_done   = 0;
    addr_viol  = 0;
    cur_base   = 16'h1000;

    // Basic load, cycle by cycle: start, 18 words back to back, FLUSH, DONE, IDLE.
    vecs[0] = '{start: 1'b1, in_valid: 1'b0, in_data: 16'h0, exp_ready: 1'b1, exp_we: 1'b0,
                exp_addr: 5'd0, exp_din: 16'h0, exp_busy: 1'b1, exp_done: 1'b0, exp_kv: 1'b0};
    for (int k = 0; k < N; k++) begin
      vecs[1+k].start     = 1'b0;
      vecs[1+k].in_valid  = 1'b1;
      vecs[1+k].in_data   = 16'h1000 + W'(k);
      vecs[1+k].exp_ready = (k != N - 1);
      vecs[1+k].exp_we    = 1'b1;
      vecs[1+k].exp_addr  = AW'(k);
      vecs[1+k].exp_din   = 16'h1000 + W'(k);
      vecs[1+k].exp_busy  = 1'b1;
      vecs[1+k].exp_done  = 1'b0;
      vecs[1+k].exp_kv    = 1'b0;
    end
    vecs[N+1] = '{start: 1'b0, in_valid: 1'b0, in_data: 16'h0, exp_ready: 1'b0, exp_we: 1'b0,
                  exp_addr: 5'd17, exp_din: 16'h1011, exp_busy: 1'b0, exp_done: 1'b1, exp_kv: 1'b0};
    vecs[N+2] = '{start: 1'b0, in_valid: 1'b0, in_data: 16'h0, exp_ready: 1'b0, exp_we: 1'b0,
                  exp_addr: 5'd17, exp_din: 16'h1011, exp_busy: 1'b0, exp_done: 1'b0, exp_kv: 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    for (int i = 0; i <= N + 2; i++) begin
      start    = vecs[i].start;
      in_valid = vecs[i].in_valid;
      in_data  = vecs[i].in_data;
      step();
      chk("tbl_in_ready", 32'(in_ready), 32'(vecs[i].exp_ready));
      chk("tbl_write_en", 32'(write_en), 32'(vecs[i].exp_we));
      chk("tbl_write_addr", 32'(write_addr), 32'(vecs[i].exp_addr));
      chk("tbl_din", 32'(din), 32'(vecs[i].exp_din));
      chk("tbl_busy", 32'(busy), 32'(vecs[i].exp_busy));
      chk("tbl_done", 32'(done), 32'(vecs[i].exp_done));
      chk("tbl_kv", 32'(kernel_valid), 32'(vecs[i].exp_kv));
      $display("vec %0d: we=%0b addr=%0d din=0x%0h done=%0b kv=%0b",
               i, write_en, write_addr, din, done, kernel_valid);
    end
    exp_done++;
    chk("basic_done_count", 32'(done_count), 32'(exp_done));
    chk_regs("basic", 16'h1000);

    // Stalled stream with a different kernel, then the same Basic kernel with
    // start pulses that must be ignored (mid-load and in FLUSH).
    load_kernel(16'h5000, 1, -1, 1'b0);
    chk_regs("stall", 16'h5000);
    $display("stall load complete, done_count=%0d", done_count);
    load_kernel(16'h1000, 1, 5, 1'b1);
    chk_regs("ignored_start", 16'h1000);
    $display("ignored-start load complete, done_count=%0d", done_count);

    // Reset at word 9 abandons the load; a fresh load then fills everything.
    cur_base = 16'h3000;
    exp_addr = 0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_data = 16'h3000 + W'(k);
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    exp_addr = 0;
    chk_reset_outputs("midrst");
    step();
    chk("midrst_idle_ready", 32'(in_ready), 32'd0);
    chk("midrst_idle_kv", 32'(kernel_valid), 32'd0);
    $display("reset mid-load applied");
    load_kernel(16'h2000, 0, -1, 1'b0);
    chk_regs("after_rst", 16'h2000);
    $display("post-reset load complete, done_count=%0d", done_count);

    // Back-to-back: load_kernel issues start the cycle after done.
    load_kernel(16'hA000, 0, -1, 1'b0);
    chk_regs("b2b", 16'hA000);
    $display("back-to-back load complete, done_count=%0d", done_count);

    // Randomised gaps over many loads; no write may target 18..31.
    rbase = 16'h0;
    for (int n = 0; n < 1000; n++) begin
      rbase = W'($urandom_range(0, 16'hFFE0));
      load_kernel(rbase, 2, -1, 1'b0);
    end
    chk("addr_bound_violations", 32'(addr_viol), 32'd0);
    chk_regs("random_last", rbase);
    $display("random loads complete, done_count=%0d", done_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
